// File: rtl/ieee754_to_fixed_pipe.sv
`timescale 1ns/1ps
// ieee754_to_fixed_pipe
// Three-stage pipelined converter from IEEE-754 binary64 to a signed or
// unsigned fixed-point word with FRAC_W fractional bits. Each sample carries
// its own rounding mode (truncate or round-to-nearest-even). Out-of-range
// results saturate. Status flags travel with the data.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready = out_ready | ~out_valid)
//   in_data[63:0]         binary64 sample
//   in_rnd                0 = truncate toward zero, 1 = round-to-nearest-even
//   out_valid/out_ready   output handshake
//   out_data[OUT_W-1:0]   fixed-point result
//   out_ovf               result saturated (overflow, infinity, negative when unsigned)
//   out_nan               input was NaN, out_data = 0
//   out_inexact           nonzero bits discarded, or input was subnormal
module ieee754_to_fixed_pipe #(
   parameter int OUT_W  = 16,
   parameter int FRAC_W = 0,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   input  logic             in_rnd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic             out_nan,
   output logic             out_inexact
);

   // Magnitude field has one spare bit so a rounding carry is never lost
   // before the range check.
   localparam int MAG_W  = OUT_W + 1;
   localparam int WIDE_W = 53 + MAG_W;

   localparam logic [MAG_W-1:0] POS_LIM = SIGNED ? MAG_W'((64'd1 << (OUT_W - 1)) - 64'd1)
                                                 : MAG_W'((64'd1 << OUT_W) - 64'd1);
   localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(64'd1 << (OUT_W - 1));
   localparam logic [OUT_W-1:0] SAT_MAX = SIGNED ? {1'b0, {(OUT_W - 1){1'b1}}} : {OUT_W{1'b1}};
   localparam logic [OUT_W-1:0] SAT_MIN = SIGNED ? {1'b1, {(OUT_W - 1){1'b0}}} : {OUT_W{1'b0}};

   // The whole pipeline advances as one; it only holds when a result is
   // waiting and downstream refuses it.
   logic adv;
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // ---------------- Stage 1: unpack and classify ----------------
   logic [10:0]        in_exp;
   logic [51:0]        in_frac;
   logic               s1_valid, s1_sign, s1_nan, s1_inf, s1_zero, s1_sub, s1_rnd;
   logic [52:0]        s1_sig;
   logic signed [12:0] s1_sh;

   assign in_exp  = in_data[62:52];
   assign in_frac = in_data[51:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_sign  <= in_data[63];
         s1_nan   <= (in_exp == 11'h7FF) && (in_frac != 52'd0);
         s1_inf   <= (in_exp == 11'h7FF) && (in_frac == 52'd0);
         s1_zero  <= (in_exp == 11'd0);
         s1_sub   <= (in_exp == 11'd0) && (in_frac != 52'd0);
         s1_sig   <= {1'b1, in_frac};
         // Position of the integer LSB relative to significand bit 0.
         s1_sh    <= $signed({2'b00, in_exp}) - 13'sd1075 + $signed(13'(FRAC_W));
         s1_rnd   <= in_rnd;
      end
   end

   // ---------------- Stage 2: align and round ----------------
   logic [WIDE_W-1:0] wide_l;
   logic [107:0]      wide_r;
   logic [12:0]       neg_sh;
   logic [5:0]        rsh;
   logic [52:0]       r_int;
   logic [MAG_W:0]    mag_rnd;
   logic [MAG_W-1:0]  mag_c;
   logic              pre_ovf_c, guard_c, sticky_c, inexact_c, inc_c;

   always_comb begin
      wide_l    = '0;
      wide_r    = '0;
      neg_sh    = '0;
      rsh       = '0;
      r_int     = '0;
      mag_rnd   = '0;
      mag_c     = '0;
      pre_ovf_c = 1'b0;
      guard_c   = 1'b0;
      sticky_c  = 1'b0;
      inexact_c = 1'b0;
      inc_c     = 1'b0;
      if (s1_zero) begin
         // Zero and subnormals convert to 0; subnormals lose bits.
         inexact_c = s1_sub;
      end else if (!s1_sh[12]) begin
         // Left shift: the leading 1 already sits at bit 52, so any shift
         // beyond the field width is an overflow regardless of the rest.
         if (s1_sh > 13'(MAG_W)) begin
            pre_ovf_c = 1'b1;
         end else begin
            wide_l    = {{MAG_W{1'b0}}, s1_sig} << s1_sh[5:0];
            pre_ovf_c = |wide_l[WIDE_W-1:MAG_W];
            mag_c     = wide_l[MAG_W-1:0];
         end
      end else begin
         // Right shift. Clamping to 55 keeps the whole significand inside the
         // guard/sticky window for arbitrarily large shifts.
         neg_sh    = 13'(-s1_sh);
         rsh       = (neg_sh > 13'd54) ? 6'd55 : neg_sh[5:0];
         wide_r    = {s1_sig, 55'd0} >> rsh;
         r_int     = wide_r[107:55];
         guard_c   = wide_r[54];
         sticky_c  = |wide_r[53:0];
         inexact_c = guard_c | sticky_c;
         inc_c     = s1_rnd & guard_c & (sticky_c | r_int[0]);
         mag_rnd   = {1'b0, r_int[MAG_W-1:0]} + {{MAG_W{1'b0}}, inc_c};
         pre_ovf_c = (|r_int[52:MAG_W]) | mag_rnd[MAG_W];
         mag_c     = mag_rnd[MAG_W-1:0];
      end
   end

   logic             s2_valid, s2_sign, s2_nan, s2_inf, s2_pre_ovf, s2_inexact;
   logic [MAG_W-1:0] s2_mag;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (adv) begin
         s2_valid   <= s1_valid;
         s2_sign    <= s1_sign;
         s2_nan     <= s1_nan;
         s2_inf     <= s1_inf;
         s2_pre_ovf <= pre_ovf_c;
         s2_inexact <= inexact_c;
         s2_mag     <= mag_c;
      end
   end

   // ---------------- Stage 3: sign and saturate ----------------
   logic [OUT_W-1:0] res_data;
   logic             res_ovf, res_nan, res_inexact, big;

   always_comb begin
      res_data    = '0;
      res_ovf     = 1'b0;
      res_nan     = 1'b0;
      res_inexact = s2_inexact;
      big         = s2_inf | s2_pre_ovf;
      if (s2_nan) begin
         res_nan     = 1'b1;
         res_inexact = 1'b0;
      end else if (!s2_sign) begin
         if (big || (s2_mag > POS_LIM)) begin
            res_data = SAT_MAX;
            res_ovf  = 1'b1;
         end else begin
            res_data = s2_mag[OUT_W-1:0];
         end
      end else if (SIGNED) begin
         // The most negative value has magnitude one above the positive max.
         if (big || (s2_mag > NEG_LIM)) begin
            res_data = SAT_MIN;
            res_ovf  = 1'b1;
         end else begin
            res_data = {OUT_W{1'b0}} - s2_mag[OUT_W-1:0];
         end
      end else begin
         // Unsigned: -0.0 (or a negative that rounded to 0) is not an overflow.
         if (big || (s2_mag != '0)) begin
            res_data = SAT_MIN;
            res_ovf  = 1'b1;
         end
      end
      if (s2_inf) begin
         res_inexact = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_ovf     <= 1'b0;
         out_nan     <= 1'b0;
         out_inexact <= 1'b0;
      end else if (adv) begin
         out_valid   <= s2_valid;
         out_data    <= res_data;
         out_ovf     <= res_ovf;
         out_nan     <= res_nan;
         out_inexact <= res_inexact;
      end
   end

endmodule
